// File: rtl/glb_seq_ctrl.sv
// GLB load -> PE tag flush -> PE kernel flush -> compute start sequencer; outputs registered, 1-cycle input-to-output latency.
// full stalls load beats cycle by cycle; optional watchdog on the wait states under GLB_SEQ_TIMEOUT_EN.
module glb_seq_ctrl #(
   parameter int LOAD_W    = 16,
   parameter int MIN_PULSE = 4,
   parameter int GAP       = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              go,
   input  logic [LOAD_W-1:0] load_len,
   input  logic              ram_rst_busy,
   input  logic              full,
   input  logic              tag_busy,
   input  logic              kernel_busy,
   output logic              load_ifmap,
   output logic              load_fltr,
   output logic              load_psum,
   output logic              flush_tag,
   output logic              flush_kernel,
   output logic              start,
   output logic              busy,
   output logic              err,
   output logic [LOAD_W-1:0] beats
);

   localparam int CNT_MAX = (GAP > MIN_PULSE) ? GAP : MIN_PULSE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(MIN_PULSE - 1);

   typedef enum logic [8:0] {
      IDLE     = 9'b0_0000_0001,
      WAIT_RST = 9'b0_0000_0010,
      LOAD     = 9'b0_0000_0100,
      GAP1     = 9'b0_0000_1000,
      FTAG     = 9'b0_0001_0000,
      GAP2     = 9'b0_0010_0000,
      FKER     = 9'b0_0100_0000,
      GAP3     = 9'b0_1000_0000,
      RUN      = 9'b1_0000_0000
   } state_t;

   state_t            state_q, state_d;
   logic [LOAD_W-1:0] len_q, len_d;
   logic [LOAD_W-1:0] beats_q, beats_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              load_q, load_d;
   logic              ftag_q, ftag_d;
   logic              fker_q, fker_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
`ifdef GLB_SEQ_TIMEOUT_EN
   logic [15:0]       wd_q, wd_d;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         len_q   <= '0;
         beats_q <= '0;
         cnt_q   <= '0;
         load_q  <= 1'b0;
         ftag_q  <= 1'b0;
         fker_q  <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef GLB_SEQ_TIMEOUT_EN
         wd_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         beats_q <= beats_d;
         cnt_q   <= cnt_d;
         load_q  <= load_d;
         ftag_q  <= ftag_d;
         fker_q  <= fker_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
`ifdef GLB_SEQ_TIMEOUT_EN
         wd_q    <= wd_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      beats_d = beats_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      load_d  = 1'b0;
`ifdef GLB_SEQ_TIMEOUT_EN
      wd_d    = '0;
`endif

      // A RAM clear once the sequence has moved past WAIT_RST means the buffer was wiped under us.
      if ((state_q != IDLE) && (state_q != WAIT_RST) && ram_rst_busy)
         err_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (go) begin
               state_d = WAIT_RST;
               len_d   = load_len;
               beats_d = '0;
            end
         end
         WAIT_RST: begin
            if (!ram_rst_busy) begin
               if (len_q == '0) begin
                  state_d = GAP1;
                  cnt_d   = '0;
               end else begin
                  state_d = LOAD;
                  load_d  = !full;
                  beats_d = beats_q + LOAD_W'(!full);
               end
            end
         end
         LOAD: begin
            // beats_q already counts the beat presented this cycle, so equality means done.
            if (beats_q == len_q) begin
               state_d = GAP1;
               cnt_d   = '0;
            end else begin
               load_d  = !full;
               beats_d = beats_q + LOAD_W'(!full);
            end
         end
         GAP1, GAP2, GAP3: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (state_q == GAP1)      state_d = FTAG;
               else if (state_q == GAP2) state_d = FKER;
               else                      state_d = RUN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FTAG, FKER: begin
            // cnt saturates at PULSE_LAST once the minimum pulse width has been served.
            if (cnt_q == PULSE_LAST) begin
               if ((state_q == FTAG) ? !tag_busy : !kernel_busy) begin
                  state_d = (state_q == FTAG) ? GAP2 : GAP3;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef GLB_SEQ_TIMEOUT_EN
      if ((state_d == state_q) &&
          ((state_q == WAIT_RST) || (state_q == FTAG) || (state_q == FKER))) begin
         if (wd_q == 16'hFFFE) begin
            state_d = IDLE;
            err_d   = 1'b1;
            beats_d = '0;
            cnt_d   = '0;
         end else begin
            wd_d = wd_q + 16'd1;
         end
      end
`endif

      ftag_d  = (state_d == FTAG);
      fker_d  = (state_d == FKER);
      start_d = (state_d == RUN);
      busy_d  = (state_d != IDLE);
   end

   assign load_ifmap   = load_q;
   assign load_fltr    = load_q;
   assign load_psum    = load_q;
   assign flush_tag    = ftag_q;
   assign flush_kernel = fker_q;
   assign start        = start_q;
   assign busy         = busy_q;
   assign err          = err_q;
   assign beats        = beats_q;

endmodule

// File: tb/tb_glb_seq_ctrl.sv
// Randomized sequences for glb_seq_ctrl checked every cycle against a phase-level reference model,
// plus per-sequence pulse-length and beat-count checks on the observed outputs.
module tb_glb_seq_ctrl;

   localparam int LOAD_W    = 16;
   localparam int MIN_PULSE = 4;
   localparam int GAP       = 2;

   localparam int P_IDLE = 0, P_WAIT = 1, P_LOAD = 2, P_GAP1 = 3, P_FTAG = 4,
                  P_GAP2 = 5, P_FKER = 6, P_GAP3 = 7, P_RUN = 8;

   logic              clk, rstn, go;
   logic [LOAD_W-1:0] load_len;
   logic              ram_rst_busy, full, tag_busy, kernel_busy;
   logic              load_ifmap, load_fltr, load_psum;
   logic              flush_tag, flush_kernel, start, busy, err;
   logic [LOAD_W-1:0] beats;

   int n_vec = 0;
   int n_bad = 0;

   int m_phase, m_len, m_beats, m_left;
   bit m_load, m_err;
`ifdef GLB_SEQ_TIMEOUT_EN
   int m_cyc = 0;
   int m_entry = 0;
`endif

   glb_seq_ctrl #(.LOAD_W(LOAD_W), .MIN_PULSE(MIN_PULSE), .GAP(GAP)) dut (
      .clk(clk), .rstn(rstn), .go(go), .load_len(load_len),
      .ram_rst_busy(ram_rst_busy), .full(full), .tag_busy(tag_busy), .kernel_busy(kernel_busy),
      .load_ifmap(load_ifmap), .load_fltr(load_fltr), .load_psum(load_psum),
      .flush_tag(flush_tag), .flush_kernel(flush_kernel), .start(start),
      .busy(busy), .err(err), .beats(beats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE;
      m_len   = 0;
      m_beats = 0;
      m_left  = 0;
      m_load  = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic model_issue();
      m_load = !full;
      if (!full) m_beats++;
   endtask

   task automatic model_step();
      int prev;
      if (!rstn) begin
         model_reset();
         return;
      end
      prev = m_phase;
      if (m_phase != P_IDLE && m_phase != P_WAIT && ram_rst_busy) m_err = 1'b1;
      m_load = 1'b0;
      case (m_phase)
         P_IDLE: if (go) begin m_phase = P_WAIT; m_len = int'(load_len); m_beats = 0; end
         P_WAIT: if (!ram_rst_busy) begin
            if (m_len == 0) begin m_phase = P_GAP1; m_left = GAP; end
            else begin m_phase = P_LOAD; model_issue(); end
         end
         P_LOAD: begin
            if (m_beats == m_len) begin m_phase = P_GAP1; m_left = GAP; end
            else model_issue();
         end
         P_GAP1, P_GAP2, P_GAP3: begin
            m_left--;
            if (m_left == 0) begin
               m_phase = (m_phase == P_GAP1) ? P_FTAG : (m_phase == P_GAP2) ? P_FKER : P_RUN;
               m_left  = MIN_PULSE;
            end
         end
         P_FTAG: begin
            if (m_left > 1) m_left--;
            else if (!tag_busy) begin m_phase = P_GAP2; m_left = GAP; end
         end
         P_FKER: begin
            if (m_left > 1) m_left--;
            else if (!kernel_busy) begin m_phase = P_GAP3; m_left = GAP; end
         end
         default: ;
      endcase
`ifdef GLB_SEQ_TIMEOUT_EN
      m_cyc++;
      if (m_phase != prev) m_entry = m_cyc;
      else if ((prev == P_WAIT || prev == P_FTAG || prev == P_FKER) && (m_cyc - m_entry == 65535)) begin
         m_phase = P_IDLE;
         m_err   = 1'b1;
         m_beats = 0;
      end
`endif
   endtask

   task automatic check_outs();
      chk("outs", {24'd0, load_ifmap, load_fltr, load_psum, flush_tag, flush_kernel, start, busy, err},
                  {24'd0, m_load, m_load, m_load, m_phase == P_FTAG, m_phase == P_FKER,
                   m_phase == P_RUN, m_phase != P_IDLE, m_err});
      chk("beats", 32'(beats), 32'(m_beats));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outs();
   endtask

   // Entered and left on a falling edge; the assertion lands mid-cycle so it must act without a clock.
   task automatic do_reset();
      #2 rstn = 1'b0;
      #1 model_reset();
      check_outs();
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic run_seq(input int len, input int rrb_hold, input int full_pct, input bit bp,
                          input int tb_hold, input int kb_hold, input bit glitch, input bit abort);
      int wait_k, ftag_k, fker_k, run_k, budget, exp_fker;
      int load_cnt, ftag_hi, fker_hi, gap2, start_cnt;
      int hold [10];
      bit done;
      wait_k = 0; ftag_k = 0; fker_k = 0; run_k = 0;
      load_cnt = 0; ftag_hi = 0; fker_hi = 0; gap2 = 0; start_cnt = 0;
      done = 1'b0;
      foreach (hold[i]) hold[i] = 0;
      budget = 1000 + rrb_hold + tb_hold + kb_hold;

      go = 1'b1; load_len = LOAD_W'(len);
      ram_rst_busy = 1'b1; full = 1'b0; tag_busy = 1'b1; kernel_busy = 1'b1;
      tick();
      go = 1'b0;

      for (int i = 0; i < budget && !done; i++) begin
         if (abort && m_phase == P_FTAG && ftag_k == 2) begin
            do_reset();
            done = 1'b1;
         end else begin
            load_len = LOAD_W'($urandom);
            go = ($urandom_range(0, 3) == 0);
            ram_rst_busy = 1'b0;
            if (m_phase == P_WAIT) begin
               ram_rst_busy = (wait_k < rrb_hold);
               wait_k++;
            end else if (glitch && m_phase == P_GAP2) begin
               ram_rst_busy = 1'b1;
            end
            if (bp) begin
               full = 1'b0;
               if (m_phase == P_LOAD && m_beats >= 5 && m_beats <= 9 && m_beats < m_len && hold[m_beats] < 3) begin
                  full = 1'b1;
                  hold[m_beats]++;
               end
            end else begin
               full = ($urandom_range(0, 99) < full_pct);
            end
            if (m_phase == P_FTAG) begin tag_busy = (ftag_k < tb_hold); ftag_k++; end
            else tag_busy = 1'($urandom_range(0, 1));
            if (m_phase == P_FKER) begin kernel_busy = (fker_k < kb_hold); fker_k++; end
            else kernel_busy = 1'($urandom_range(0, 1));

            tick();

            load_cnt  += int'(load_ifmap);
            ftag_hi   += int'(flush_tag);
            fker_hi   += int'(flush_kernel);
            start_cnt += int'(start);
            if (ftag_hi > 0 && fker_hi == 0 && !flush_tag && !flush_kernel) gap2++;
            if (m_phase == P_RUN) run_k++;
            if (run_k >= 3 || m_phase == P_IDLE) done = 1'b1;
         end
      end

      if (!done) chk("seq_budget", 32'd0, 32'd1);
      if (!abort) begin
         exp_fker = imax(MIN_PULSE, kb_hold + 1);
`ifdef GLB_SEQ_TIMEOUT_EN
         if (exp_fker > 65535) exp_fker = 65535;
`endif
         chk("load_cnt", 32'(load_cnt), 32'(len));
         chk("ftag_len", 32'(ftag_hi), 32'(imax(MIN_PULSE, tb_hold + 1)));
         chk("gap2_len", 32'(gap2), 32'(GAP));
         chk("fker_len", 32'(fker_hi), 32'(exp_fker));
         chk("start_seen", 32'(start_cnt > 0), 32'(exp_fker < 65535));
      end
      do_reset();
   endtask

   initial begin
      rstn = 1'b0; go = 1'b0; load_len = '0;
      ram_rst_busy = 1'b0; full = 1'b0; tag_busy = 1'b0; kernel_busy = 1'b0;
      model_reset();
      tick();
      tick();
      rstn = 1'b1;

      //       len rrb full bp tb  kb  glitch abort
      run_seq(50,  3,  0,  0, 10,   6, 0, 0);
      run_seq(20,  2,  0,  1,  3,   3, 0, 0);
      run_seq( 0,  4,  0,  0,  5,   5, 0, 0);
      run_seq(30,  1,  0,  0, 10,   6, 0, 1);
      run_seq(50,  3,  0,  0, 10,   6, 0, 0);
      run_seq(12,  0, 30,  0,  0,   0, 0, 0);
      run_seq( 8,  2, 20,  0,  4,   7, 1, 0);
      run_seq( 5,  1,  0,  0,  2, 300, 0, 0);
      for (int s = 0; s < 25; s++) begin
         run_seq($urandom_range(0, 40), $urandom_range(0, 6), $urandom_range(0, 60), 1'b0,
                 $urandom_range(0, 12), $urandom_range(0, 12),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      end
`ifdef GLB_SEQ_TIMEOUT_EN
      run_seq(6, 2, 0, 0, 3, 70000, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
